// File: rtl/mult_share_arbiter.sv
// Shares one pipelined DW x DW multiplier between NREQ clients; tags follow each operation to its owner.
// Build option: define MULT_SHARE_FIXED_PRIO_EN for fixed priority (index 0 highest) instead of round-robin.
module mult_share_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 16,
  parameter int LAT  = 2
) (
  input  logic                 Clock,
  input  logic                 Aclr,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*DW-1:0]   req_a,
  input  logic [NREQ*DW-1:0]   req_b,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      res_valid,
  output logic [2*DW-1:0]      res_data,
  output logic [DW-1:0]        mult_DataA,
  output logic [DW-1:0]        mult_DataB,
  output logic                 mult_ClkEn,
  input  logic [2*DW-1:0]      mult_Result,
  output logic                 busy
);

  localparam int IW = $clog2(NREQ);
  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  typedef struct packed {
    logic          valid;
    logic [IW-1:0] id;
  } tag_t;

  logic [IW-1:0]   gnt_idx;
  logic            gnt_any;
  logic            gnt_fire;
  tag_t [LAT-1:0]  tag_q;
  logic [DW-1:0]   a_q, b_q;
  logic            clken_q;
  logic [NREQ-1:0] res_valid_q;
  logic [2*DW-1:0] res_data_q;

`ifdef MULT_SHARE_FIXED_PRIO_EN
  // Scanning downwards lets the lowest requesting index overwrite the others.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        gnt_idx = IW'(i);
        gnt_any = 1'b1;
      end
    end
  end
`else
  localparam int SW = IW + 1;

  logic [IW-1:0] rr_q;
  logic [SW-1:0] slot;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    slot    = '0;
    for (int i = 0; i < NREQ; i++) begin
      slot = {1'b0, rr_q} + SW'(i);
      if (slot >= SW'(NREQ)) slot = slot - SW'(NREQ);
      if (!gnt_any && req[slot[IW-1:0]]) begin
        gnt_idx = slot[IW-1:0];
        gnt_any = 1'b1;
      end
    end
  end

  always_ff @(posedge Clock or posedge Aclr) begin
    if (Aclr) begin
      rr_q <= '0;
    end else if (gnt_fire) begin
      rr_q <= (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + IW'(1);
    end
  end
`endif

  // Grants are suppressed while reset is held so nothing is accepted into a clearing pipeline.
  assign gnt_fire = gnt_any & ~Aclr;
  assign gnt      = gnt_fire ? (ONE << gnt_idx) : '0;

  // NOTE: sequential state uses non-blocking assignments so the tag shift reads pre-edge values.
  always_ff @(posedge Clock or posedge Aclr) begin
    if (Aclr) begin
      clken_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      tag_q       <= '0;
      res_valid_q <= '0;
      res_data_q  <= '0;
    end else begin
      clken_q <= 1'b1;
      if (gnt_fire) begin
        a_q <= req_a[gnt_idx*DW +: DW];
        b_q <= req_b[gnt_idx*DW +: DW];
      end
      tag_q[0].valid <= gnt_fire;
      tag_q[0].id    <= gnt_idx;
      for (int s = 1; s < LAT; s++) tag_q[s] <= tag_q[s-1];
      res_valid_q <= tag_q[LAT-1].valid ? (ONE << tag_q[LAT-1].id) : '0;
      if (tag_q[LAT-1].valid) res_data_q <= mult_Result;
    end
  end

  always_comb begin
    busy = gnt_fire;
    for (int s = 0; s < LAT; s++) busy = busy | tag_q[s].valid;
  end

  assign mult_DataA = a_q;
  assign mult_DataB = b_q;
  assign mult_ClkEn = clken_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter: a driver pushes expected products, a monitor pops them on res_valid.
module tb_mult_share_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 16;
  localparam int LAT  = 2;

  logic              Clock = 1'b0;
  logic              Aclr  = 1'b1;
  logic [NREQ-1:0]   req   = '0;
  logic [NREQ*DW-1:0] req_a = '0;
  logic [NREQ*DW-1:0] req_b = '0;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   res_valid;
  logic [2*DW-1:0]   res_data;
  logic [DW-1:0]     mult_DataA;
  logic [DW-1:0]     mult_DataB;
  logic              mult_ClkEn;
  logic [2*DW-1:0]   mult_Result = '0;
  logic              busy;

  mult_share_arbiter #(.NREQ(NREQ), .DW(DW), .LAT(LAT)) dut (
    .Clock       (Clock),
    .Aclr        (Aclr),
    .req         (req),
    .req_a       (req_a),
    .req_b       (req_b),
    .gnt         (gnt),
    .res_valid   (res_valid),
    .res_data    (res_data),
    .mult_DataA  (mult_DataA),
    .mult_DataB  (mult_DataB),
    .mult_ClkEn  (mult_ClkEn),
    .mult_Result (mult_Result),
    .busy        (busy)
  );

  always #5 Clock = ~Clock;

  // Multiplier IP model: one internal stage after the block's operand registers (LAT = 2 overall).
  always @(posedge Clock) begin
    if (mult_ClkEn) mult_Result <= {16'h0, mult_DataA} * {16'h0, mult_DataB};
  end

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  typedef struct {
    int          id;
    logic [31:0] prod;
    int          due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge Clock) begin
    if (!Aclr) begin
      if (sb.size() != 0 && sb[0].due == cyc) begin
        mon_e = sb.pop_front();
        check("res_valid", 64'(res_valid), 64'(4'b0001 << mon_e.id));
        check("res_data", 64'(res_data), 64'(mon_e.prod));
      end else if (res_valid != '0) begin
        check("res_valid_unexpected", 64'(res_valid), 64'h0);
      end
    end
  end

  // exp_id < 0 means no grant expected; exp_busy 2 skips the busy check.
  task automatic step(input int exp_id, input logic [31:0] exp_prod, input int exp_busy);
    logic [3:0] eg;
    eg = (exp_id < 0) ? 4'b0000 : (4'b0001 << exp_id);
    @(negedge Clock);
    check("gnt", 64'(gnt), 64'(eg));
    if (exp_busy != 2) check("busy", 64'(busy), 64'(exp_busy));
    if (exp_id >= 0) sb.push_back('{exp_id, exp_prod, cyc + 1 + LAT});
    @(posedge Clock);
    #1;
  endtask

  task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
    req_a[i*DW +: DW] = a;
    req_b[i*DW +: DW] = b;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"},       64'(gnt),        64'h0);
    check({tag, "_res_valid"}, 64'(res_valid),  64'h0);
    check({tag, "_res_data"},  64'(res_data),   64'h0);
    check({tag, "_dataa"},     64'(mult_DataA), 64'h0);
    check({tag, "_datab"},     64'(mult_DataB), 64'h0);
    check({tag, "_busy"},      64'(busy),       64'h0);
    check({tag, "_clken"},     64'(mult_ClkEn), 64'h0);
  endtask

  task automatic apply_reset();
    Aclr = 1'b1;
    sb.delete();
    @(posedge Clock);
    #1;
    Aclr = 1'b0;
  endtask

  task automatic drain();
    step(-1, 32'h0, 1);
    step(-1, 32'h0, 1);
    step(-1, 32'h0, 0);
  endtask

  initial begin
    logic [15:0] ca [4];
    logic [15:0] cb [4];
    int          id;

    // Reset state, with every requester asking: nothing may be granted.
    repeat (2) @(posedge Clock);
    #1;
    req = 4'b1111;
    @(negedge Clock);
    check_reset_outputs("reset");
    @(posedge Clock);
    #1;
    req  = '0;
    Aclr = 1'b0;
    step(-1, 32'h0, 0);
    check("clken_after_reset", 64'(mult_ClkEn), 64'h1);

    // Single request from requester 2.
    set_op(2, 16'h1234, 16'h0010);
    req = 4'b0100;
    step(2, 32'h0001_2340, 1);
    req = '0;
    drain();

    // All requesters contend from rr = 0.
    apply_reset();
    ca = '{16'h0011, 16'h0123, 16'h0A00, 16'h8001};
    cb = '{16'h0022, 16'h0100, 16'h0003, 16'h0002};
    for (int i = 0; i < NREQ; i++) set_op(i, ca[i], cb[i]);
    req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
`ifdef MULT_SHARE_FIXED_PRIO_EN
      id = 0;
`else
      id = k % NREQ;
`endif
      step(id, {16'h0, ca[id]} * {16'h0, cb[id]}, 1);
    end
    req = '0;
    drain();

    // Maximum operands.
    set_op(0, 16'hFFFF, 16'hFFFF);
    req = 4'b0001;
    step(0, 32'hFFFE_0001, 1);
    req = '0;
    drain();

    // Back-to-back issue from requester 1, operands changing after each grant.
    req = 4'b0010;
    set_op(1, 16'd3, 16'd4);
    step(1, 32'd12, 1);
    set_op(1, 16'd5, 16'd6);
    step(1, 32'd30, 1);
    set_op(1, 16'd7, 16'd8);
    step(1, 32'd56, 1);
    req = '0;
    drain();

    // Reset one cycle after a grant to requester 0: the product must never appear.
    set_op(0, 16'd9, 16'd9);
    req = 4'b0001;
    step(0, 32'd81, 1);
    req  = '0;
    Aclr = 1'b1;
    sb.delete();
    @(negedge Clock);
    check_reset_outputs("midflight");
    @(posedge Clock);
    #1;
    Aclr = 1'b0;
    // rr was 1 before reset; a cleared pointer must pick requester 0 here.
    set_op(0, 16'd4, 16'd5);
    set_op(1, 16'd2, 16'd3);
    req = 4'b0011;
    step(0, 32'd20, 1);
    set_op(3, 16'h00AB, 16'h0100);
    req = 4'b1000;
    step(3, 32'h0000_AB00, 1);
    req = '0;
    drain();

    // Two requesters held: alternate under round-robin, requester 0 always under fixed priority.
    set_op(0, 16'd2, 16'd2);
    set_op(1, 16'd3, 16'd3);
    req = 4'b0011;
    for (int k = 0; k < 4; k++) begin
`ifdef MULT_SHARE_FIXED_PRIO_EN
      id = 0;
`else
      id = k % 2;
`endif
      step(id, (id == 0) ? 32'd4 : 32'd9, 1);
    end
    req = '0;
    drain();

    step(-1, 32'h0, 0);
    check("scoreboard_empty", 64'(sb.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
- Shares the single pipelined 16x16 `multiplier` IP instance between NREQ client blocks, e.g. distance calculation, angle compensation and temperature correction.
- Arbitrates round-robin, registers the winning operands into the multiplier, and tracks ownership through the multiplier pipeline with a tag shift register.
- Returns each product to its owner with a one-cycle valid pulse.
- Sits between the client blocks and the multiplier instance in the IP wrapper.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DW, 16, operand width; product width is 2*DW.
- LAT, 2, multiplier IP pipeline latency in cycles from operands registered at its input to Result valid.

Ports:
- Clock  in  1  system clock; all logic on the rising edge.
- Aclr  in  1  asynchronous reset, active-high.
- req  in  NREQ  per-requester operation request, level.
- req_a  in  NREQ*DW  flattened operand A; requester i uses bits [i*DW +: DW].
- req_b  in  NREQ*DW  flattened operand B; same packing as req_a.
- gnt  out  NREQ  one-hot accept pulse, combinational.
- res_valid  out  NREQ  one-hot result pulse, registered.
- res_data  out  2*DW  product, valid when any res_valid bit is set.
- mult_DataA  out  DW  to multiplier DataA, registered.
- mult_DataB  out  DW  to multiplier DataB, registered.
- mult_ClkEn  out  1  multiplier clock enable.
- mult_Result  in  2*DW  from multiplier Result.
- busy  out  1  high while any operation is in flight.

Behaviour:
- Reset (Aclr=1, asynchronous):
  - gnt=0, res_valid=0, res_data=0, mult_DataA=0, mult_DataB=0, busy=0, mult_ClkEn=0.
  - rr pointer=0; all tag stages cleared (valid=0).
- After reset release, mult_ClkEn=1 constantly; the pipeline never stalls.
- Handshake:
  - A requester raises req[i] with stable operands and holds them until gnt[i]=1.
  - gnt[i] is a single-cycle pulse in the cycle the operands are taken; one gnt accepts exactly one multiply.
  - A requester may keep req high to issue back-to-back operations, changing operands in the cycle after each gnt.
  - Dropping req before gnt cancels the request; no side effect.
- Arbitration:
  - Combinational round-robin over req starting at index rr; at most one gnt bit set per cycle.
  - On a grant to index k, rr <= (k+1) mod NREQ at the clock edge.
  - No grant means rr is unchanged.
  - Throughput: one accept per cycle.
- Issue: on the grant edge, mult_DataA/mult_DataB <= the granted operands, and tag stage 0 <= {valid=1, id=k}. With no grant, the operand registers hold their value and the tag stage 0 valid is 0.
- Tag pipeline:
  - Depth LAT; advances every cycle.
  - Final stage drives a registered one-hot res_valid and res_data <= mult_Result on the same edge.
  - Latency: gnt in cycle T -> res_valid[k]=1 with product in cycle T+1+LAT (T+3 at default).
- Ordering: results return in grant order. A single requester issuing back-to-back gets consecutive res_valid pulses.
- busy = OR of tag stage valids plus the issue stage; low only when no product is outstanding.
- res_data holds its last value when res_valid=0.
- Arithmetic: unsigned DW x DW -> 2*DW, fully computed by the IP; there is no truncation in this block.
- Reset mid-operation: all in-flight tags are discarded, and no res_valid is produced for operations granted before reset.
- Simultaneous events: a new grant in the same cycle as a result return is allowed; the two are independent.

Optional Feature:
- Macro: MULT_SHARE_FIXED_PRIO_EN.
- Defined:
  - Fixed priority, lowest index wins; rr is not implemented.
  - Requester 0 can starve the others; intended for the distance path, which must never wait.
- Undefined (default): round-robin as above.

Test Plan:
- Single request:
  - Stimulus: req[2]=1, a=0x1234, b=0x0010 at cycle 5.
  - Response: gnt[2] at 5; res_valid=4'b0100 at cycle 8, res_data=0x00012340; busy high cycles 5..7.
- All contend:
  - Stimulus: req=4'b1111 held for 8 cycles with rr=0.
  - Response: gnt order 0,1,2,3,0,1,2,3; res_valid follows the same order 3 cycles later, each product correct.
- Max operands:
  - Stimulus: a=b=0xFFFF.
  - Response: res_data=0xFFFE0001.
- Back-to-back from one requester:
  - Stimulus: req[1] held with operands changing each cycle (3x4, 5x6, 7x8).
  - Response: three consecutive res_valid[1] pulses with 12, 30, 56.
- Reset mid-flight:
  - Stimulus: Aclr pulsed one cycle after gnt[0].
  - Response: no res_valid thereafter; all outputs 0; rr=0; a subsequent req[3] is granted immediately.
- With MULT_SHARE_FIXED_PRIO_EN:
  - Stimulus: req=4'b0011 held.
  - Response: gnt[0] every cycle and gnt[1] never; with the macro undefined, gnt alternates 0,1.
